// File: rtl/booth_multiplier.sv
// booth_multiplier: sequential radix-4 Booth signed multiplier with start/ready handshake
module booth_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   P,
    output logic                 ready
);
    localparam int CW = $clog2(WIDTH/2 + 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t              state_q;
    logic [2*WIDTH-1:0]  m_q, acc_q, acc_d, p_q, m2, pp;
    logic [WIDTH:0]      b_q;
    logic [CW-1:0]       cnt_q;
    logic                ready_q;
    // Booth recoding of the low triplet of the shifting multiplier selects the partial product
    always_comb begin
        m2    = {m_q[2*WIDTH-2:0], 1'b0};
        pp    = (b_q[2:0] == 3'b001 || b_q[2:0] == 3'b010) ? m_q :
                (b_q[2:0] == 3'b011) ? m2 :
                (b_q[2:0] == 3'b100) ? -m2 :
                (b_q[2:0] == 3'b101 || b_q[2:0] == 3'b110) ? -m_q : '0;
        acc_d = acc_q + pp;
    end
    // Control FSM; the multiplicand shifts left and the multiplier right by two each iteration
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (start) begin
                        m_q     <= {{WIDTH{A[WIDTH-1]}}, A};
                        b_q     <= {B, 1'b0};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == CW'(WIDTH/2)) begin
                        p_q     <= acc_q;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        m_q   <= {m_q[2*WIDTH-3:0], 2'b00};
                        b_q   <= {{2{b_q[WIDTH]}}, b_q[WIDTH:2]};
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        ready_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign P     = p_q;
    assign ready = ready_q;
endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier: directed vectors with hand-computed signed products for WIDTH=4
module tb_booth_multiplier;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic [7:0] P;
    logic       ready;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] prev = '0;

    booth_multiplier #(.WIDTH(4)) dut (
        .clock(clock), .reset(reset), .start(start),
        .A(A), .B(B), .P(P), .ready(ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // start already high with operands driven; walks load, two iterations, completion, hold, release
    task automatic run_calc(input string tag, input logic [7:0] exp);
        @(posedge clock); #1;
        check({tag, "_e0_ready"}, {7'b0, ready}, 8'h00);
        check({tag, "_e0_p"}, P, prev);
        A = ~A;
        B = B + 4'd5;
        @(posedge clock); #1;
        check({tag, "_e1_ready"}, {7'b0, ready}, 8'h00);
        check({tag, "_e1_p"}, P, prev);
        @(posedge clock); #1;
        check({tag, "_e2_ready"}, {7'b0, ready}, 8'h00);
        check({tag, "_e2_p"}, P, prev);
        @(posedge clock); #1;
        check({tag, "_ready"}, {7'b0, ready}, 8'h01);
        check({tag, "_p"}, P, exp);
        @(posedge clock); #1;
        check({tag, "_hold_ready"}, {7'b0, ready}, 8'h01);
        check({tag, "_hold_p"}, P, exp);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock); #1;
        check({tag, "_drop_ready"}, {7'b0, ready}, 8'h00);
        check({tag, "_drop_p"}, P, exp);
        prev = exp;
    endtask

    task automatic do_mul(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
        @(negedge clock);
        A = a;
        B = b;
        start = 1'b1;
        run_calc(tag, exp);
    endtask

    initial begin
        #12;
        check("rst_p", P, 8'h00);
        check("rst_ready", {7'b0, ready}, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_ready", {7'b0, ready}, 8'h00);
        check("idle_p", P, 8'h00);
        do_mul("m1x3", 4'd1, 4'd3, 8'h03);
        do_mul("m1xn3", 4'd1, 4'hD, 8'hFD);
        do_mul("mn1x3", 4'hF, 4'd3, 8'hFD);
        do_mul("mn1xn3", 4'hF, 4'hD, 8'h03);
        do_mul("mn8xn8", 4'h8, 4'h8, 8'h40);
        do_mul("mn8x7", 4'h8, 4'd7, 8'hC8);
        do_mul("m7x7", 4'd7, 4'd7, 8'h31);
        do_mul("m0xn5", 4'd0, 4'hB, 8'h00);
        do_mul("mn8x1", 4'h8, 4'd1, 8'hF8);
        do_mul("m5xn6", 4'd5, 4'hA, 8'hE2);
        do_mul("mn7xn7", 4'h9, 4'h9, 8'h31);
        do_mul("m6x2", 4'd6, 4'd2, 8'h0C);
        @(negedge clock);
        A = 4'd2;
        B = 4'd5;
        start = 1'b1;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_p", P, 8'h00);
        check("abort_ready", {7'b0, ready}, 8'h00);
        prev = 8'h00;
        A = 4'd3;
        B = 4'hE;
        @(negedge clock);
        reset = 1'b0;
        run_calc("m3xn2", 8'hFA);
        do_mul("mn4x4", 4'hC, 4'd4, 8'hF0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
